// File: rtl/bikelight_pkg.sv
// Shared bikelight constants: button FSM state encoding and default timing.
// Imported by the button conditioner, its interface and the mode FSM.
// Holds no logic; types and constants only.
package bikelight_pkg;

  localparam int STATE_W = 3;

  // Codes 5..7 are unused and recover to IDLE in the conditioner FSM.
  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    PRESS_DB  = 3'd1,
    HELD      = 3'd2,
    LONG_HELD = 3'd3,
    REL_DB    = 3'd4
  } btn_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 8;
  localparam int LONG_CYCLES_DEF     = 128;
  localparam int REPEAT_CYCLES_DEF   = 32;
  localparam int CNT_W_DEF           = 8;

  // True when a state code is one of the five defined states.
  function automatic logic state_is_legal(logic [STATE_W-1:0] code);
    return code <= 3'd4;
  endfunction

endpackage

// File: rtl/btn_conditioner_if.sv
// Button conditioner bundle: raw pin in, debounced level and event pulses out.
// master = pin/consumer side, slave = conditioner side.
// No flow control; pulses are single-cycle and must be consumed when seen.
interface btn_conditioner_if;
  import bikelight_pkg::*;

  logic               btn;
  logic               btn_level;
  logic               press_pulse;
  logic               release_pulse;
  logic               long_pulse;
  logic [STATE_W-1:0] state;

  modport master (
    output btn,
    input  btn_level, press_pulse, release_pulse, long_pulse, state
  );

  modport slave (
    input  btn,
    output btn_level, press_pulse, release_pulse, long_pulse, state
  );

endinterface

// File: rtl/btn_sync.sv
// Two-flop synchronizer for a single asynchronous bit.
// Latency: 2 clk edges from input change to output change.
// No backpressure; output follows the input continuously.
module btn_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  // Metastability filter: first flop may go metastable, second resolves it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/btn_conditioner.sv
// Bikelight button conditioner: sync + debounce + press/release/long-press pulses.
// Latency: DEBOUNCE_CYCLES+2 edges from first sample of a new level to its pulse.
// No backpressure; pulses are one cycle wide. Optional auto-repeat: BTN_REPEAT_EN.
module btn_conditioner
  import bikelight_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  btn_conditioner_if.slave   bus
);

  // Reject configurations where a counter could wrap before its compare hits.
  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2 || REPEAT_CYCLES < 1 ||
      (1 << CNT_W) <= DEBOUNCE_CYCLES || (1 << CNT_W) <= LONG_CYCLES ||
      (1 << CNT_W) <= REPEAT_CYCLES) begin : g_bad_params
    $error("btn_conditioner: illegal timing parameters for CNT_W");
  end

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic sync_btn;

  btn_sync u_sync (
    .clk (clk),
    .rst (reset),
    .d_i (bus.btn),
    .q_o (sync_btn)
  );

  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] dcnt_q, dcnt_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             long_flag_q, long_flag_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
`endif

  // State, counters and registered outputs; reset drops everything at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dcnt_q      <= '0;
      hcnt_q      <= '0;
      long_flag_q <= 1'b0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
`ifdef BTN_REPEAT_EN
      rcnt_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      hcnt_q      <= hcnt_d;
      long_flag_q <= long_flag_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
`ifdef BTN_REPEAT_EN
      rcnt_q      <= rcnt_d;
`endif
    end
  end

  // Next state plus the pulse that marks the transition being taken, so each
  // pulse lands in the first cycle of its target state.
  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    hcnt_d      = hcnt_q;
    long_flag_d = long_flag_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
`ifdef BTN_REPEAT_EN
    rcnt_d      = rcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (sync_btn) begin
          state_d = PRESS_DB;
          dcnt_d  = '0;
        end
      end
      PRESS_DB: begin
        if (!sync_btn) begin
          state_d = IDLE;
        end else if (dcnt_q == DB_LAST) begin
          state_d     = HELD;
          hcnt_d      = '0;
          long_flag_d = 1'b0;
          press_d     = 1'b1;
        end else begin
          dcnt_d = dcnt_q + CNT_ONE;
        end
      end
      HELD: begin
        if (!sync_btn) begin
          state_d = REL_DB;
          dcnt_d  = '0;
        end else if (hcnt_q == LONG_LAST) begin
          state_d     = LONG_HELD;
          long_flag_d = 1'b1;
          long_d      = 1'b1;
`ifdef BTN_REPEAT_EN
          rcnt_d      = '0;
`endif
        end else begin
          hcnt_d = hcnt_q + CNT_ONE;
        end
      end
      LONG_HELD: begin
        if (!sync_btn) begin
          state_d = REL_DB;
          dcnt_d  = '0;
        end
`ifdef BTN_REPEAT_EN
        else if (rcnt_q == REP_LAST) begin
          rcnt_d  = '0;
          press_d = 1'b1;
        end else begin
          rcnt_d = rcnt_q + CNT_ONE;
        end
`endif
      end
      REL_DB: begin
        // hcnt (and rcnt) stay frozen so a release glitch resumes timing.
        if (sync_btn) begin
          state_d = long_flag_q ? LONG_HELD : HELD;
        end else if (dcnt_q == DB_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    level_d = (state_d == HELD) || (state_d == LONG_HELD) || (state_d == REL_DB);
  end

  assign bus.btn_level     = level_q;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;
  assign bus.long_pulse    = long_q;
  assign bus.state         = state_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with default timing (8 / 128 / 32).
// Stimulus pushes expected {pulse, cycle} events; a negedge monitor pops them.
// Cycle stamps count rising edges; s = edge that first samples a btn change.
module tb_btn_conditioner;
  import bikelight_pkg::*;

  localparam int K_PRESS = 0;
  localparam int K_LONG  = 1;
  localparam int K_REL   = 2;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  ev_t  exp_q[$];
  int   state_log[$];
  int   prev_state = 0;
  bit   saw_held = 1'b0;
  bit   saw_level = 1'b0;
  int   npulse;

  btn_conditioner_if bus ();

  btn_conditioner dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  function automatic string kname(int k);
    case (k)
      K_PRESS: return "press";
      K_LONG:  return "long";
      default: return "release";
    endcase
  endfunction

  task automatic check(string name, int act, int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(int kind, int at);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic match(int kind);
    ev_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_%s: got pulse at cycle %0d, required none", kname(kind), cyc);
    end else begin
      e = exp_q.pop_front();
      check("pulse_kind", kind, e.kind);
      check($sformatf("%s_cycle", kname(e.kind)), cyc, e.at);
    end
  endtask

  // Monitor: compares every pulse against the scoreboard, records state trace.
  always @(negedge clk) begin
    npulse = int'(bus.press_pulse) + int'(bus.long_pulse) + int'(bus.release_pulse);
    if (npulse > 1) check("one_pulse_max", npulse, 1);
    if (bus.press_pulse)   match(K_PRESS);
    if (bus.long_pulse)    match(K_LONG);
    if (bus.release_pulse) match(K_REL);
    if (int'(bus.state) >= 2) saw_held = 1'b1;
    if (bus.btn_level) saw_level = 1'b1;
    if (int'(bus.state) != prev_state) begin
      prev_state = int'(bus.state);
      state_log.push_back(prev_state);
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; the change is first sampled on the next rising edge.
  task automatic drive_btn(logic v, output int s);
    bus.btn = v;
    s = cyc + 1;
  endtask

  task automatic drain(string name);
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_quiet(string tag);
    check({tag, "_state"},   int'(bus.state), 0);
    check({tag, "_level"},   int'(bus.btn_level), 0);
    check({tag, "_press"},   int'(bus.press_pulse), 0);
    check({tag, "_long"},    int'(bus.long_pulse), 0);
    check({tag, "_release"}, int'(bus.release_pulse), 0);
  endtask

  initial begin
    int s;
    int k;
    int exp_log[5];
    reset   = 1'b1;
    bus.btn = 1'b0;
    tick(3);
    check_quiet("reset");
    reset = 1'b0;
    tick(5);

    // Clean press: 160 cycles held, then released.
    drive_btn(1'b1, s);
    expect_ev(K_PRESS, s + 10);
    expect_ev(K_LONG,  s + 138);
    expect_ev(K_REL,   s + 170);
    tick(10);
    check("clean_level_before_press", int'(bus.btn_level), 0);
    tick(1);
    check("clean_level_at_press", int'(bus.btn_level), 1);
    tick(149);
    drive_btn(1'b0, k);
    tick(10);
    check("clean_level_before_release", int'(bus.btn_level), 1);
    tick(1);
    check("clean_level_after_release", int'(bus.btn_level), 0);
    tick(20);
    drain("clean_pending");

    // Bounce: toggles every 3 cycles must never reach HELD.
    saw_held  = 1'b0;
    saw_level = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_btn(1'b1, s);
      tick(3);
      drive_btn(1'b0, s);
      tick(3);
    end
    tick(30);
    check("bounce_saw_held", int'(saw_held), 0);
    check("bounce_saw_level", int'(saw_level), 0);
    check("bounce_state", int'(bus.state), 0);
    drain("bounce_pending");

    // Release glitch of 4 cycles: hcnt freezes for the 5 edges spent leaving
    // and re-entering HELD, so long fires at press+128+5, not restarted.
    drive_btn(1'b1, s);
    expect_ev(K_PRESS, s + 10);
    expect_ev(K_LONG,  s + 143);
    expect_ev(K_REL,   s + 174);
    tick(100);
    drive_btn(1'b0, k);
    tick(4);
    check("glitch_level_held", int'(bus.btn_level), 1);
    drive_btn(1'b1, k);
    tick(60);
    drive_btn(1'b0, k);
    tick(20);
    drain("glitch_pending");

    // Short press: no long pulse; state walks 0,1,2,4,0.
    state_log.delete();
    state_log.push_back(int'(bus.state));
    drive_btn(1'b1, s);
    expect_ev(K_PRESS, s + 10);
    expect_ev(K_REL,   s + 50);
    tick(40);
    drive_btn(1'b0, k);
    tick(25);
    drain("short_pending");
    exp_log = '{0, 1, 2, 4, 0};
    check("short_log_len", state_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < state_log.size()) check($sformatf("short_log_%0d", i), state_log[i], exp_log[i]);
    end

    // Reset mid-press: outputs clear at once, then a fresh debounce from reset exit.
    drive_btn(1'b1, s);
    expect_ev(K_PRESS, s + 10);
    tick(20);
    reset = 1'b1;
    #1;
    check_quiet("midrst_async");
    @(negedge clk);
    check_quiet("midrst_held");
    reset = 1'b0;
    expect_ev(K_PRESS, s + 31);
    expect_ev(K_REL,   s + 60);
    tick(29);
    drive_btn(1'b0, k);
    tick(20);
    drain("midrst_pending");

`ifdef BTN_REPEAT_EN
    // Auto-repeat: press re-fires every 32 cycles after long.
    drive_btn(1'b1, s);
    expect_ev(K_PRESS, s + 10);
    expect_ev(K_LONG,  s + 138);
    expect_ev(K_PRESS, s + 170);
    expect_ev(K_PRESS, s + 202);
    expect_ev(K_PRESS, s + 234);
    expect_ev(K_PRESS, s + 266);
    expect_ev(K_PRESS, s + 298);
    expect_ev(K_REL,   s + 310);
    tick(300);
    drive_btn(1'b0, k);
    tick(20);
    drain("repeat_pending");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
